cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: per-source result FIFO depth, a power of two, at least 2.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 3: the number of consecutive lost arbitrations after which EXE is forced to win.
REQ-003 Port CLK  input  1: clock; all state SHALL update on the rising edge.
REQ-004 Port RESET  input  1: asynchronous, active-low reset.
REQ-005 Port STALL  input  1: pipeline freeze.
REQ-006 Port FLUSH  input  1: synchronous squash.
REQ-007 Ports exe_valid / mem_valid  input  1: a result is offered by that source.
REQ-008 Ports exe_map / mem_map  input  6: destination physical register.
REQ-009 Ports exe_val / mem_val  input  32: result value.
REQ-010 Ports exe_rob / mem_rob  input  6: ROB index.
REQ-011 Ports exe_ready / mem_ready  output  1: the source may push this cycle.
REQ-012 Port cdb_valid  output  1: broadcast is valid; Issue and ROB sample it.
REQ-013 Ports cdb_map / cdb_val / cdb_rob  output  6/32/6: broadcast payload.
REQ-014 Port cdb_src  output  1: 0 = EXE, 1 = MEM.

Function
REQ-015 A push SHALL be accepted on a rising edge where x_valid and x_ready are both 1; pushes with x_ready low SHALL be ignored.
REQ-016 x_ready SHALL be computed from registered occupancy only: (count < DEPTH) and !STALL and !FLUSH.
REQ-017 An accepted push with x_map == 0 SHALL be discarded and never broadcast.
REQ-018 One entry at most SHALL be broadcast per cycle; cdb_* outputs SHALL be registered.
REQ-019 Arbitration SHALL use the FIFO heads: MEM wins when both are non-empty, unless starve_cnt == STARVE_LIMIT, in which case EXE wins.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle EXE is non-empty and not granted, and SHALL clear on an EXE grant or when the EXE FIFO is empty.
REQ-021 The winner SHALL be popped on the same edge that loads cdb_*; with no winner, cdb_valid SHALL be 0 and the payload SHALL hold its previous value.
REQ-022 Simultaneous push and pop on one FIFO SHALL leave count unchanged and preserve order; pointers SHALL wrap modulo DEPTH.
REQ-023 Latency without bypass: a push accepted at edge N, winning immediately, SHALL appear with cdb_valid high after edge N+1.
REQ-024 STALL SHALL freeze FIFOs, starve_cnt and all cdb_* outputs (held, not cleared), so a broadcast is never lost.
REQ-025 FLUSH SHALL take priority over STALL: it empties both FIFOs, clears starve_cnt and cdb_valid, and accepts no push that cycle.

Reset
REQ-026 While RESET == 0, cdb_valid, cdb_map, cdb_val, cdb_rob, cdb_src, starve_cnt, FIFO pointers and counts SHALL be 0; exe_ready and mem_ready SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results; after release, the first broadcast SHALL occur only from a new push.

Configuration
REQ-028 With CDB_BYPASS_EN defined, an accepted push into an empty FIFO SHALL compete in the same cycle, and if it wins SHALL appear after edge N (1-cycle latency) without being stored; the REQ-019 priority still applies.
REQ-029 With CDB_BYPASS_EN undefined, every result SHALL pass through its FIFO (REQ-023 latency); the ports are identical in both builds.

Structure
REQ-030 Package cdb_pkg SHALL hold PREG_W = 6, ROB_W = 6, DATA_W = 32, the cdb_entry_t struct {map, val, rob}, and the constants SRC_EXE = 0 and SRC_MEM = 1.
REQ-031 A single sub-module cdb_fifo (DEPTH, cdb_entry_t, push/pop/count/head) SHALL be instantiated twice; arbitration, starvation and output registers SHALL live in the top level.

Verification
REQ-032 Push EXE {map 5, val 0xDEADBEEF, rob 3} at edge 1: cdb_valid = 1 after edge 2 with that payload and cdb_src = 0; with CDB_BYPASS_EN, after edge 1.
REQ-033 Push EXE {map 7} and MEM {map 9} at the same edge: MEM (map 9) SHALL broadcast first and EXE (map 7) on the next cycle.
REQ-034 Hold MEM continuously valid with EXE holding one entry, STARVE_LIMIT = 3: EXE SHALL win on the 4th arbitration cycle, then starve_cnt SHALL be 0.
REQ-035 Fill EXE with 4 entries while blocked: exe_ready SHALL be 0, a 5th push SHALL be dropped, and entries SHALL drain in order through pointer wrap.
REQ-036 Assert STALL for 3 cycles with cdb_valid = 1 (map 12): outputs SHALL be held and FIFOs unchanged; a push with map 0 SHALL never produce a broadcast.
REQ-037 Assert FLUSH (alone, then together with STALL), and drop RESET mid-drain: cdb_valid SHALL be 0 next cycle, both FIFOs empty, and no stale broadcast SHALL appear afterwards.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared widths, payload type and source encodings for the common data bus
// arbiter and its result FIFOs.
package cdb_pkg;

  localparam int PREG_W = 6;
  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  localparam logic SRC_EXE = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [PREG_W-1:0] map;
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  rob;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source and broadcast bundle of the CDB arbiter. The arbiter takes the
// slave view; the producer/consumer side takes the master view.
interface cdb_arbiter_if;
  import cdb_pkg::*;

  logic              exe_valid;
  logic [PREG_W-1:0] exe_map;
  logic [DATA_W-1:0] exe_val;
  logic [ROB_W-1:0]  exe_rob;
  logic              exe_ready;

  logic              mem_valid;
  logic [PREG_W-1:0] mem_map;
  logic [DATA_W-1:0] mem_val;
  logic [ROB_W-1:0]  mem_rob;
  logic              mem_ready;

  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_map;
  logic [DATA_W-1:0] cdb_val;
  logic [ROB_W-1:0]  cdb_rob;
  logic              cdb_src;

  modport slave (
    input  exe_valid, exe_map, exe_val, exe_rob,
    input  mem_valid, mem_map, mem_val, mem_rob,
    output exe_ready, mem_ready,
    output cdb_valid, cdb_map, cdb_val, cdb_rob, cdb_src
  );

  modport master (
    output exe_valid, exe_map, exe_val, exe_rob,
    output mem_valid, mem_map, mem_val, mem_rob,
    input  exe_ready, mem_ready,
    input  cdb_valid, cdb_map, cdb_val, cdb_rob, cdb_src
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result FIFO: power-of-two depth, wrapping pointers, registered
// occupancy count, head entry visible combinationally.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  cdb_entry_t             data_i,
  input  logic                   pop_i,
  output cdb_entry_t             head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  cdb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (!push_i && pop_i) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only meaningful while
  // count_q covers it, so clearing the array would buy nothing.
  always_ff @(posedge CLK) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: EXE and MEM result FIFOs, MEM-priority arbitration
// with EXE starvation override, registered broadcast. CDB_BYPASS_EN lets a push
// into an empty FIFO compete in the same cycle.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           STALL,
  input  logic           FLUSH,
  cdb_arbiter_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  cdb_entry_t    exe_in, mem_in, exe_head, mem_head, exe_cand, mem_cand;
  logic [CW-1:0] exe_count, mem_count;
  logic          exe_rdy, mem_rdy, exe_acc, mem_acc;
  logic          exe_byp, mem_byp, exe_has, mem_has;
  logic          exe_gnt, mem_gnt, exe_push, mem_push, exe_pop, mem_pop;

  logic [SW-1:0] starve_q, starve_d;
  cdb_entry_t    cdb_q, cdb_d;
  logic          cdb_valid_q, cdb_valid_d;
  logic          cdb_src_q, cdb_src_d;

  assign exe_in = cdb_entry_t'{map: bus.exe_map, val: bus.exe_val, rob: bus.exe_rob};
  assign mem_in = cdb_entry_t'{map: bus.mem_map, val: bus.mem_val, rob: bus.mem_rob};

  // Ready depends only on registered occupancy and the pipeline controls.
  assign exe_rdy = RESET && !STALL && !FLUSH && (exe_count < FIFO_FULL);
  assign mem_rdy = RESET && !STALL && !FLUSH && (mem_count < FIFO_FULL);
  assign bus.exe_ready = exe_rdy;
  assign bus.mem_ready = mem_rdy;

  // Results for physical register 0 are accepted but never stored or sent.
  assign exe_acc = bus.exe_valid && exe_rdy && (bus.exe_map != '0);
  assign mem_acc = bus.mem_valid && mem_rdy && (bus.mem_map != '0);

`ifdef CDB_BYPASS_EN
  assign exe_byp = exe_acc && (exe_count == '0);
  assign mem_byp = mem_acc && (mem_count == '0);
`else
  assign exe_byp = 1'b0;
  assign mem_byp = 1'b0;
`endif

  assign exe_has  = (exe_count != '0) || exe_byp;
  assign mem_has  = (mem_count != '0) || mem_byp;
  assign exe_cand = (exe_count != '0) ? exe_head : exe_in;
  assign mem_cand = (mem_count != '0) ? mem_head : mem_in;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    exe_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!STALL && !FLUSH) begin
      if (exe_has && mem_has) begin
        if (starve_q == STARVE_MAX) exe_gnt = 1'b1;
        else                        mem_gnt = 1'b1;
      end else if (exe_has) begin
        exe_gnt = 1'b1;
      end else if (mem_has) begin
        mem_gnt = 1'b1;
      end
    end
  end

  // A bypassed winner is broadcast straight away and never written.
  assign exe_push = exe_acc && !(exe_byp && exe_gnt);
  assign mem_push = mem_acc && !(mem_byp && mem_gnt);
  assign exe_pop  = exe_gnt && (exe_count != '0);
  assign mem_pop  = mem_gnt && (mem_count != '0);

  always_comb begin
    starve_d    = starve_q;
    cdb_valid_d = cdb_valid_q;
    cdb_d       = cdb_q;
    cdb_src_d   = cdb_src_q;
    if (FLUSH) begin
      starve_d    = '0;
      cdb_valid_d = 1'b0;
    end else if (!STALL) begin
      if (!exe_has || exe_gnt)      starve_d = '0;
      else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
      cdb_valid_d = exe_gnt || mem_gnt;
      if (mem_gnt) begin
        cdb_d     = mem_cand;
        cdb_src_d = SRC_MEM;
      end else if (exe_gnt) begin
        cdb_d     = exe_cand;
        cdb_src_d = SRC_EXE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      starve_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      cdb_src_q   <= SRC_EXE;
    end else begin
      starve_q    <= starve_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_map   = cdb_q.map;
  assign bus.cdb_val   = cdb_q.val;
  assign bus.cdb_rob   = cdb_q.rob;
  assign bus.cdb_src   = cdb_src_q;

  cdb_fifo #(.DEPTH(DEPTH)) u_exe_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .flush_i (FLUSH),
    .push_i  (exe_push),
    .data_i  (exe_in),
    .pop_i   (exe_pop),
    .head_o  (exe_head),
    .count_o (exe_count)
  );

  cdb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .flush_i (FLUSH),
    .push_i  (mem_push),
    .data_i  (mem_in),
    .pop_i   (mem_pop),
    .head_o  (mem_head),
    .count_o (mem_count)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (DEPTH 4, STARVE_LIMIT 3): cycle table plus
// hand-written reset, flush and latency sequences.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic STALL = 1'b0;
  logic FLUSH = 1'b0;

  always #5 CLK = ~CLK;

  cdb_arbiter_if bus ();

  cdb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .STALL (STALL),
    .FLUSH (FLUSH),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         stall, flush, ev;
    logic [5:0] em;
    bit         mv;
    logic [5:0] mm;
    bit         erdy, mrdy, cv;
    logic [5:0] cm;
    bit         cs;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Payload derived from the destination register so held values are predictable.
  function automatic logic [31:0] val_of(input logic [5:0] m);
    return (m == 6'd0) ? 32'h0 : (32'hA5A5_0000 | 32'(m));
  endfunction

  function automatic logic [5:0] rob_of(input logic [5:0] m);
    return (m == 6'd0) ? 6'h0 : ~m;
  endfunction

  task automatic add(input bit stall, flush, ev, input logic [5:0] em, input bit mv,
                     input logic [5:0] mm, input bit erdy, mrdy, cv,
                     input logic [5:0] cm, input bit cs);
    vec_t v;
    v = '{stall, flush, ev, em, mv, mm, erdy, mrdy, cv, cm, cs};
    vecs.push_back(v);
  endtask

  task automatic drive(input bit stall, flush, ev, input logic [5:0] em, input bit mv,
                       input logic [5:0] mm);
    STALL         = stall;
    FLUSH         = flush;
    bus.exe_valid = ev;
    bus.exe_map   = em;
    bus.exe_val   = val_of(em);
    bus.exe_rob   = rob_of(em);
    bus.mem_valid = mv;
    bus.mem_map   = mm;
    bus.mem_val   = val_of(mm);
    bus.mem_rob   = rob_of(mm);
  endtask

  task automatic check_cdb(input string tag, input bit v, input logic [5:0] m, input bit s);
    check({tag, " cdb_valid"}, 32'(bus.cdb_valid), 32'(v));
    check({tag, " cdb_map"},   32'(bus.cdb_map),   32'(m));
    check({tag, " cdb_val"},   bus.cdb_val,        val_of(m));
    check({tag, " cdb_rob"},   32'(bus.cdb_rob),   32'(rob_of(m)));
    check({tag, " cdb_src"},   32'(bus.cdb_src),   32'(s));
  endtask

  task automatic step_idle();
    @(negedge CLK);
    drive(0, 0, 0, 6'd0, 0, 6'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state, with valids asserted to show ready stays low.
    drive(0, 0, 1, 6'd5, 1, 6'd5);
    #2;
    check_cdb("reset", 0, 6'd0, 0);
    check("reset exe_ready", 32'(bus.exe_ready), 32'd0);
    check("reset mem_ready", 32'(bus.mem_ready), 32'd0);
    @(negedge CLK);
    drive(0, 0, 0, 6'd0, 0, 6'd0);
    RESET = 1'b1;

`ifndef CDB_BYPASS_EN
    //  stall flush ev em  mv mm   erdy mrdy cv cm cs
    add(0, 0, 1, 6'd7,  1, 6'd9,  1, 1, 0, 6'd0,  0);  // simultaneous push
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd9,  1);  // MEM first
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd7,  0);  // then EXE
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 0, 6'd7,  0);  // idle holds payload
    add(0, 0, 1, 6'd1,  1, 6'd2,  1, 1, 0, 6'd7,  0);  // starvation setup
    add(0, 0, 0, 6'd0,  1, 6'd3,  1, 1, 1, 6'd2,  1);
    add(0, 0, 0, 6'd0,  1, 6'd4,  1, 1, 1, 6'd3,  1);
    add(0, 0, 0, 6'd0,  1, 6'd5,  1, 1, 1, 6'd4,  1);
    add(0, 0, 0, 6'd0,  1, 6'd6,  1, 1, 1, 6'd1,  0);  // 4th arbitration: EXE
    add(0, 0, 1, 6'd10, 1, 6'd8,  1, 1, 1, 6'd5,  1);
    add(0, 0, 0, 6'd0,  1, 6'd11, 1, 1, 1, 6'd6,  1);  // counter restarted at 0
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd8,  1);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd11, 1);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd10, 0);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 0, 6'd10, 0);
    add(0, 0, 1, 6'd21, 1, 6'd31, 1, 1, 0, 6'd10, 0);  // fill EXE while blocked
    add(0, 0, 1, 6'd22, 1, 6'd32, 1, 1, 1, 6'd31, 1);
    add(0, 0, 1, 6'd23, 1, 6'd33, 1, 1, 1, 6'd32, 1);
    add(0, 0, 1, 6'd24, 1, 6'd34, 1, 1, 1, 6'd33, 1);
    add(0, 0, 1, 6'd25, 1, 6'd35, 0, 1, 1, 6'd21, 0);  // full: 25 dropped
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd34, 1);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd35, 1);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd22, 0);  // in-order drain across wrap
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd23, 0);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd24, 0);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 0, 6'd24, 0);
    add(0, 0, 1, 6'd12, 0, 6'd0,  1, 1, 0, 6'd24, 0);
    add(0, 0, 1, 6'd0,  1, 6'd13, 1, 1, 1, 6'd12, 0);  // map 0 push discarded
    add(1, 0, 0, 6'd0,  1, 6'd14, 0, 0, 1, 6'd12, 0);  // stall x3 holds outputs
    add(1, 0, 0, 6'd0,  1, 6'd14, 0, 0, 1, 6'd12, 0);
    add(1, 0, 0, 6'd0,  1, 6'd14, 0, 0, 1, 6'd12, 0);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd13, 1);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 0, 6'd13, 1);  // nothing from map 0
    add(0, 0, 1, 6'd40, 1, 6'd41, 1, 1, 0, 6'd13, 1);
    add(0, 0, 1, 6'd42, 1, 6'd43, 1, 1, 1, 6'd41, 1);
    add(0, 1, 1, 6'd44, 1, 6'd45, 0, 0, 0, 6'd41, 1);  // flush alone
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 0, 6'd41, 1);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 0, 6'd41, 1);
    add(0, 0, 1, 6'd50, 1, 6'd51, 1, 1, 0, 6'd41, 1);
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 1, 6'd51, 1);
    add(1, 1, 0, 6'd0,  0, 6'd0,  0, 0, 0, 6'd51, 1);  // flush beats stall
    add(0, 0, 0, 6'd0,  0, 6'd0,  1, 1, 0, 6'd51, 1);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].stall, vecs[i].flush, vecs[i].ev, vecs[i].em, vecs[i].mv, vecs[i].mm);
      #1;
      check($sformatf("v%0d exe_ready", i), 32'(bus.exe_ready), 32'(vecs[i].erdy));
      check($sformatf("v%0d mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].mrdy));
      @(posedge CLK);
      #1;
      check_cdb($sformatf("v%0d", i), vecs[i].cv, vecs[i].cm, vecs[i].cs);
    end
`else
    // Same-edge push of both sources: MEM bypasses, EXE waits one cycle.
    @(negedge CLK);
    drive(0, 0, 1, 6'd7, 1, 6'd9);
    @(posedge CLK);
    #1;
    check_cdb("byp both", 1, 6'd9, 1);
    step_idle();
    check_cdb("byp exe", 1, 6'd7, 0);
    step_idle();
    check_cdb("byp idle", 0, 6'd7, 0);
`endif

    // Reset asserted while EXE still holds a result.
    @(negedge CLK);
    drive(0, 0, 1, 6'd60, 1, 6'd61);
    @(posedge CLK);
    step_idle();
`ifndef CDB_BYPASS_EN
    check_cdb("pre-reset", 1, 6'd61, 1);
`else
    check_cdb("pre-reset", 1, 6'd60, 0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check_cdb("mid reset", 0, 6'd0, 0);
    check("mid reset exe_ready", 32'(bus.exe_ready), 32'd0);
    check("mid reset mem_ready", 32'(bus.mem_ready), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_idle();
      check_cdb($sformatf("post reset %0d", k), 0, 6'd0, 0);
    end

    // Latency of a single EXE result.
    @(negedge CLK);
    drive(0, 0, 1, 6'd5, 0, 6'd0);
    bus.exe_val = 32'hDEADBEEF;
    bus.exe_rob = 6'd3;
    @(posedge CLK);
    #1;
`ifndef CDB_BYPASS_EN
    check("lat edge1 cdb_valid", 32'(bus.cdb_valid), 32'd0);
`else
    check("lat edge1 cdb_valid", 32'(bus.cdb_valid), 32'd1);
    check("lat edge1 cdb_map",   32'(bus.cdb_map),   32'd5);
    check("lat edge1 cdb_val",   bus.cdb_val,        32'hDEADBEEF);
`endif
    step_idle();
`ifndef CDB_BYPASS_EN
    check("lat edge2 cdb_valid", 32'(bus.cdb_valid), 32'd1);
`else
    check("lat edge2 cdb_valid", 32'(bus.cdb_valid), 32'd0);
`endif
    check("lat edge2 cdb_map", 32'(bus.cdb_map), 32'd5);
    check("lat edge2 cdb_val", bus.cdb_val,      32'hDEADBEEF);
    check("lat edge2 cdb_rob", 32'(bus.cdb_rob), 32'd3);
    check("lat edge2 cdb_src", 32'(bus.cdb_src), 32'(SRC_EXE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
